// File: rtl/apbdma_arb_pkg.sv
// Shared types and width helpers for the APB DMA channel arbiter.
// Optional watchdog macro used by the arbiter: APBDMA_ARB_WATCHDOG_EN.
package apbdma_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Beat-count width: must hold MaxBeats itself, not just MaxBeats-1.
    function automatic int LenW(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

    function automatic int IdxW(input int num_chan);
        return (num_chan > 1) ? $clog2(num_chan) : 1;
    endfunction

    localparam int NUM_CHAN_DEF  = 4;
    localparam int MAX_BEATS_DEF = 16;

    typedef logic [LenW(MAX_BEATS_DEF)-1:0] len_t;
    typedef logic [IdxW(NUM_CHAN_DEF)-1:0]  idx_t;
    typedef logic [31:0]                    beat_t;

endpackage

// File: rtl/apbdma_chan_arbiter_if.sv
// Channel-side and midend-side bus of the arbiter. master = arbiter, slave = channels/midend.
interface apbdma_chan_arbiter_if
    import apbdma_arb_pkg::*;
#(
    parameter int NumChan  = 4,
    parameter int MaxBeats = 16
);
    localparam int LW = LenW(MaxBeats);

    logic [NumChan-1:0]         chan_req_i;
    logic [NumChan-1:0][LW-1:0] chan_len_i;
    logic [NumChan-1:0]         chan_gnt_o;
    beat_t [NumChan-1:0]        chan_data_i;
    logic [NumChan-1:0]         chan_valid_i;
    logic [NumChan-1:0]         chan_ready_o;
    beat_t                      w_data_o;
    logic                       w_valid_o;
    logic                       w_ready_i;
    logic [NumChan-1:0]         burst_done_o;
    logic                       busy_o;
    logic [NumChan-1:0]         err_o;

    modport master (
        input  chan_req_i, chan_len_i, chan_data_i, chan_valid_i, w_ready_i,
        output chan_gnt_o, chan_ready_o, w_data_o, w_valid_o, burst_done_o, busy_o, err_o
    );

    modport slave (
        output chan_req_i, chan_len_i, chan_data_i, chan_valid_i, w_ready_i,
        input  chan_gnt_o, chan_ready_o, w_data_o, w_valid_o, burst_done_o, busy_o, err_o
    );

endinterface

// File: rtl/apbdma_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping.
module apbdma_rr_pick
    import apbdma_arb_pkg::*;
#(
    parameter int NumChan = 4
) (
    input  logic [NumChan-1:0]         i_req,
    input  logic [IdxW(NumChan)-1:0]   i_start,
    output logic [NumChan-1:0]         o_gnt,
    output logic [IdxW(NumChan)-1:0]   o_idx,
    output logic                       o_any
);
    localparam int IW = IdxW(NumChan);

    always_comb begin
        int                c;
        logic [IW-1:0]     w_c;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NumChan; i++) begin
            c = int'(i_start) + i;
            if (c >= NumChan) c = c - NumChan;
            w_c = IW'(c);
            if (!o_any && i_req[w_c]) begin
                o_any      = 1'b1;
                o_gnt[w_c] = 1'b1;
                o_idx      = w_c;
            end
        end
    end

endmodule

// File: rtl/apbdma_chan_arbiter.sv
// Round-robin burst arbiter sharing the midend write-beat path between NumChan channels.
// Optional stall watchdog: define APBDMA_ARB_WATCHDOG_EN.
module apbdma_chan_arbiter
    import apbdma_arb_pkg::*;
#(
    parameter int NumChan       = 4,
    parameter int MaxBeats      = 16,
    parameter int TimeoutCycles = 256
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    apbdma_chan_arbiter_if.master bus
);
    localparam int             LW        = LenW(MaxBeats);
    localparam int             IW        = IdxW(NumChan);
    localparam logic [IW-1:0]  LAST_CHAN = IW'(NumChan - 1);
    localparam logic [LW-1:0]  MAX_LEN   = LW'(MaxBeats);

    arb_state_e         r_state;
    logic [NumChan-1:0] r_gnt;
    logic [NumChan-1:0] r_done;
    logic [LW-1:0]      r_beat_cnt;
    logic [IW-1:0]      r_last_idx;

    logic [IW-1:0]      w_start;
    logic [IW-1:0]      w_pick_idx;
    logic [NumChan-1:0] w_pick_gnt;
    logic               w_pick_any;
    logic [LW-1:0]      w_len_raw;
    logic [LW-1:0]      w_len_clamped;
    logic               w_burst;
    logic               w_valid;
    logic               w_hs;

    assign w_start = (r_last_idx == LAST_CHAN) ? '0 : r_last_idx + IW'(1);

    apbdma_rr_pick #(.NumChan(NumChan)) u_pick (
        .i_req   (bus.chan_req_i),
        .i_start (w_start),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_len_raw = bus.chan_len_i[w_pick_idx];

    always_comb begin
        w_len_clamped = w_len_raw;
        if (w_len_raw == '0)         w_len_clamped = LW'(1);
        else if (w_len_raw > MAX_LEN) w_len_clamped = MAX_LEN;
    end

    // In BURST, r_last_idx is the granted channel; the beat path is a pure mux off it.
    assign w_burst          = (r_state == BURST);
    assign w_valid          = w_burst & bus.chan_valid_i[r_last_idx];
    assign w_hs             = w_valid & bus.w_ready_i;
    assign bus.w_valid_o    = w_valid;
    assign bus.w_data_o     = w_burst ? bus.chan_data_i[r_last_idx] : '0;
    assign bus.chan_ready_o = r_gnt & {NumChan{bus.w_ready_i}};
    assign bus.chan_gnt_o   = r_gnt;
    assign bus.burst_done_o = r_done;
    assign bus.busy_o       = w_burst;

`ifdef APBDMA_ARB_WATCHDOG_EN
    localparam int SW = $clog2(TimeoutCycles + 1);

    logic [SW-1:0]      r_stall;
    logic [NumChan-1:0] r_err;
    logic               w_timeout;

    assign w_timeout = w_burst && !w_hs && (r_stall == SW'(TimeoutCycles - 1));
    assign bus.err_o = r_err;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n)           r_stall <= '0;
        else if (!w_burst || w_hs) r_stall <= '0;
        else                     r_stall <= r_stall + SW'(1);
    end
`else
    assign bus.err_o = '0;
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_done     <= '0;
            r_beat_cnt <= '0;
            r_last_idx <= LAST_CHAN;
`ifdef APBDMA_ARB_WATCHDOG_EN
            r_err      <= '0;
`endif
        end else begin
            r_done <= '0;
`ifdef APBDMA_ARB_WATCHDOG_EN
            r_err  <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_gnt      <= w_pick_gnt;
                        r_beat_cnt <= w_len_clamped;
                        r_last_idx <= w_pick_idx;
                        r_state    <= BURST;
                    end
                end
                BURST: begin
                    if (w_hs) begin
                        r_beat_cnt <= r_beat_cnt - LW'(1);
                        if (r_beat_cnt == LW'(1)) begin
                            r_gnt   <= '0;
                            r_done  <= r_gnt;
                            r_state <= IDLE;
                        end
                    end
`ifdef APBDMA_ARB_WATCHDOG_EN
                    else if (w_timeout) begin
                        r_gnt   <= '0;
                        r_err   <= r_gnt;
                        r_state <= IDLE;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apbdma_chan_arbiter.sv
// Self-checking bench for apbdma_chan_arbiter: per-cycle reference model plus directed literal checks.
// Watchdog scenario is exercised when APBDMA_ARB_WATCHDOG_EN is defined.
module tb_apbdma_chan_arbiter;
    import apbdma_arb_pkg::*;

    localparam int NC = 4;
    localparam int MB = 16;
    localparam int TO = 8;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic pclk     = 1'b0;
    logic preset_n = 1'b0;

    always #5 pclk = ~pclk;

    apbdma_chan_arbiter_if #(.NumChan(NC), .MaxBeats(MB)) bus ();

    apbdma_chan_arbiter #(
        .NumChan       (NC),
        .MaxBeats      (MB),
        .TimeoutCycles (TO)
    ) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus.master)
    );

    // Reference model: who owns the path, beats left, last winner, pending pulses.
    int m_owner, m_left, m_last, m_done, m_err, m_stall;
    int cyc;
    int src_cnt [NC];

    // Observations of the DUT used by the directed literal checks.
    int          obs_hs;
    beat_t       hs_data [$];
    int          gnt_ch  [$];
    int          gnt_cyc [$];
    int          done_cnt [NC];
    int          done_cyc [NC];
    int          err_cnt  [NC];
    int          err_cyc  [NC];
    int          err_total;
    int          stray_ready;
    logic [NC-1:0] prev_gnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: actual %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > MB) return MB;
        return l;
    endfunction

    function automatic int onehot_idx(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_last  = NC - 1;
        m_done  = -1;
        m_err   = -1;
        m_stall = 0;
        for (int c = 0; c < NC; c++) src_cnt[c] = 0;
    endtask

    task automatic clear_obs();
        obs_hs      = 0;
        hs_data.delete();
        gnt_ch.delete();
        gnt_cyc.delete();
        err_total   = 0;
        stray_ready = 0;
        prev_gnt    = '0;
        for (int c = 0; c < NC; c++) begin
            done_cnt[c] = 0;
            done_cyc[c] = -1;
            err_cnt[c]  = 0;
            err_cyc[c]  = -1;
        end
    endtask

    task automatic set_data();
        for (int c = 0; c < NC; c++) bus.chan_data_i[c] = {8'(c), 24'(src_cnt[c])};
    endtask

    task automatic drive(input logic [NC-1:0] req, input int len, input logic [NC-1:0] valid,
                         input logic rdy);
        bus.chan_req_i   = req;
        bus.chan_valid_i = valid;
        bus.w_ready_i    = rdy;
        for (int c = 0; c < NC; c++) bus.chan_len_i[c] = len_t'(len);
        set_data();
    endtask

    // Expected outputs for the current cycle follow from the model state and current inputs.
    task automatic compare();
        logic [NC-1:0] e_gnt, e_ready, e_done, e_err;
        logic          e_busy, e_valid;
        beat_t         e_data;
        e_gnt = '0; e_ready = '0; e_done = '0; e_err = '0;
        e_busy = 1'b0; e_valid = 1'b0; e_data = '0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_busy         = 1'b1;
            e_valid        = bus.chan_valid_i[idx_t'(m_owner)];
            e_data         = bus.chan_data_i[idx_t'(m_owner)];
            if (bus.w_ready_i) e_ready[m_owner] = 1'b1;
        end
        if (m_done >= 0) e_done[m_done] = 1'b1;
        if (m_err >= 0)  e_err[m_err]   = 1'b1;
        check("gnt",   32'(bus.chan_gnt_o),   32'(e_gnt));
        check("busy",  32'(bus.busy_o),       32'(e_busy));
        check("valid", 32'(bus.w_valid_o),    32'(e_valid));
        check("data",  bus.w_data_o,          e_data);
        check("ready", 32'(bus.chan_ready_o), 32'(e_ready));
        check("done",  32'(bus.burst_done_o), 32'(e_done));
        check("err",   32'(bus.err_o),        32'(e_err));

        if (bus.w_valid_o && bus.w_ready_i) begin
            obs_hs++;
            hs_data.push_back(bus.w_data_o);
        end
        if ((bus.chan_ready_o & ~bus.chan_gnt_o) != '0) stray_ready++;
        for (int c = 0; c < NC; c++) begin
            if (bus.burst_done_o[c]) begin done_cnt[c]++; done_cyc[c] = cyc; end
            if (bus.err_o[c])        begin err_cnt[c]++;  err_cyc[c]  = cyc; err_total++; end
        end
        if (bus.chan_gnt_o != '0 && prev_gnt == '0) begin
            gnt_ch.push_back(onehot_idx(bus.chan_gnt_o));
            gnt_cyc.push_back(cyc);
        end
        prev_gnt = bus.chan_gnt_o;
    endtask

    task automatic model_edge();
        m_done = -1;
        m_err  = -1;
        if (m_owner < 0) begin
            bit found = 1'b0;
            for (int i = 0; i < NC; i++) begin
                int c = (m_last + 1 + i) % NC;
                if (!found && bus.chan_req_i[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_last  = c;
                    m_left  = clamp_len(int'(bus.chan_len_i[c]));
                    m_stall = 0;
                end
            end
        end else if (bus.chan_valid_i[idx_t'(m_owner)] && bus.w_ready_i) begin
            src_cnt[m_owner]++;
            m_left--;
            m_stall = 0;
            if (m_left == 0) begin
                m_done  = m_owner;
                m_owner = -1;
            end
        end else begin
            m_stall++;
`ifdef APBDMA_ARB_WATCHDOG_EN
            if (m_stall == TO) begin
                m_err   = m_owner;
                m_owner = -1;
            end
`endif
        end
        cyc++;
    endtask

    // Inputs change at posedge+1, outputs are checked on the falling edge.
    task automatic cycle();
        set_data();
        @(negedge pclk);
        compare();
        @(posedge pclk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        model_reset();
        drive('0, 0, '0, 1'b0);
        repeat (2) @(posedge pclk);
        #1 preset_n = 1'b1;
    endtask

    int t0;

    initial begin
        cyc = 0;
        clear_obs();
        do_reset();

        check("rst_gnt",  32'(bus.chan_gnt_o),   0);
        check("rst_busy", 32'(bus.busy_o),       0);
        check("rst_done", 32'(bus.burst_done_o), 0);
        check("rst_err",  32'(bus.err_o),        0);
        run(2);

        // Single channel, len 3, midend always ready.
        clear_obs();
        t0 = cyc;
        drive(4'b0010, 3, 4'b1111, 1'b1);
        cycle();
        drive(4'b0000, 3, 4'b1111, 1'b1);
        run(6);
        check("single_gnt_n",    gnt_ch.size(),    1);
        check("single_gnt_ch",   gnt_ch[0],        1);
        check("single_gnt_lat",  gnt_cyc[0] - t0,  1);
        check("single_beats",    obs_hs,           3);
        check("single_done_lat", done_cyc[1] - t0, 4);

        // Fairness: all four request len 2 continuously.
        do_reset();
        clear_obs();
        drive(4'b1111, 2, 4'b1111, 1'b1);
        run(14);
        drive(4'b0000, 2, 4'b1111, 1'b1);
        run(3);
        check("fair_n", gnt_ch.size(), 5);
        for (int i = 0; i < 5; i++) check("fair_order", gnt_ch[i], i % NC);
        for (int i = 1; i < 5; i++) check("fair_gap", gnt_cyc[i] - gnt_cyc[i-1], 3);
        check("fair_beats", obs_hs, 10);

        // Backpressure: len 4, ready toggling 1,0,1,0...
        do_reset();
        clear_obs();
        for (int i = 0; i < 10; i++) begin
            drive((i == 0) ? 4'b0001 : 4'b0000, 4, 4'b1111, (i % 2) == 0);
            cycle();
        end
        check("bp_beats", obs_hs, 4);
        for (int i = 0; i < 4; i++) check("bp_order", hs_data[i], {8'd0, 24'(i)});
        check("bp_done", done_cnt[0], 1);
        check("bp_stray_ready", stray_ready, 0);

        // Length clamping: 0 -> 1 beat, 31 -> MaxBeats beats.
        do_reset();
        clear_obs();
        drive(4'b0100, 0, 4'b1111, 1'b1);
        cycle();
        drive(4'b0000, 0, 4'b1111, 1'b1);
        run(4);
        check("clamp0_beats", obs_hs,      1);
        check("clamp0_done",  done_cnt[2], 1);
        clear_obs();
        drive(4'b1000, 31, 4'b1111, 1'b1);
        cycle();
        drive(4'b0000, 31, 4'b1111, 1'b1);
        run(20);
        check("clamp31_beats", obs_hs,      MB);
        check("clamp31_done",  done_cnt[3], 1);

        // Reset asserted after 2 of 5 beats.
        do_reset();
        clear_obs();
        drive(4'b0001, 5, 4'b1111, 1'b1);
        cycle();
        drive(4'b0000, 5, 4'b1111, 1'b1);
        run(2);
        check("mid_beats_before", obs_hs, 2);
        #2 preset_n = 1'b0;
        #1;
        check("mid_rst_gnt",   32'(bus.chan_gnt_o),   0);
        check("mid_rst_busy",  32'(bus.busy_o),       0);
        check("mid_rst_valid", 32'(bus.w_valid_o),    0);
        check("mid_rst_ready", 32'(bus.chan_ready_o), 0);
        check("mid_rst_data",  bus.w_data_o,          0);
        model_reset();
        @(posedge pclk);
        #1;
        check("mid_rst_nodone", 32'(bus.burst_done_o), 0);
        check("mid_done_cnt",   done_cnt[0],           0);
        preset_n = 1'b1;
        clear_obs();
        drive(4'b0101, 1, 4'b1111, 1'b1);
        cycle();
        drive(4'b0000, 1, 4'b1111, 1'b1);
        run(3);
        check("mid_first_winner", gnt_ch[0], 0);

`ifdef APBDMA_ARB_WATCHDOG_EN
        // Watchdog: ready held low, ch1 aborts, ch2 is granted next.
        do_reset();
        clear_obs();
        t0 = cyc;
        drive(4'b0110, 4, 4'b1111, 1'b0);
        cycle();
        drive(4'b0100, 4, 4'b1111, 1'b0);
        run(10);
        drive(4'b0000, 4, 4'b1111, 1'b1);
        run(6);
        check("wd_err_ch1",  err_cnt[1],       1);
        check("wd_err_lat",  err_cyc[1] - t0,  9);
        check("wd_no_done1", done_cnt[1],      0);
        check("wd_next_ch",  gnt_ch[1],        2);
        check("wd_next_lat", gnt_cyc[1] - t0,  10);
        check("wd_done2",    done_cnt[2],      1);
`endif

        // Randomized traffic against the model.
        do_reset();
        clear_obs();
        for (int i = 0; i < 1500; i++) begin
            logic [NC-1:0] v;
            for (int c = 0; c < NC; c++) v[c] = ($urandom_range(0, 3) != 0);
            drive(NC'($urandom_range(0, 15)), 0, v, $urandom_range(0, 3) != 0);
            for (int c = 0; c < NC; c++) bus.chan_len_i[c] = len_t'($urandom_range(0, 20));
            cycle();
        end
        check("rand_progress", 32'(obs_hs > 100), 1);
`ifndef APBDMA_ARB_WATCHDOG_EN
        check("err_tied_low", err_total, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apbdma_chan_arbiter.md
# apbdma_chan_arbiter

Round-robin burst arbiter that shares the single midend write-beat path between `NumChan` DMA channels. Each channel requests a burst of N beats. The arbiter grants one channel and muxes that channel's beat handshake onto the midend. It holds the grant until exactly N beats have transferred, then re-arbitrates. It sits between the channel frontends and the midend write interface, in the midend's destination clock domain.

## Interface
- `NumChan`, 4: number of requesting channels, 2..16.
- `MaxBeats`, 16: maximum burst length in beats.
- `TimeoutCycles`, 256: stall limit for the watchdog (see Configuration).
- `beat_t`, logic: write beat struct, passed through unmodified.
- `pclk`, in, 1: clock.
- `preset_n`, in, 1: reset, asynchronous, active-low.
- `chan_req_i`, in, NumChan: per-channel burst request, level.
- `chan_len_i`, in, NumChan x LenW: per-channel burst length in beats. LenW = $clog2(MaxBeats+1).
- `chan_gnt_o`, out, NumChan: one-hot grant, held for the whole burst.
- `chan_data_i`, in, NumChan x beat_t: per-channel beat data.
- `chan_valid_i`, in, NumChan: per-channel beat valid.
- `chan_ready_o`, out, NumChan: per-channel beat ready.
- `w_data_o`, out, beat_t: beat to midend.
- `w_valid_o`, out, 1: beat valid to midend.
- `w_ready_i`, in, 1: midend ready.
- `burst_done_o`, out, NumChan: one-cycle pulse on the channel whose burst completed.
- `busy_o`, out, 1: a burst is active.
- `err_o`, out, NumChan: watchdog abort pulse. Tied to 0 when the watchdog macro is undefined.

## Operation
- FSM states: IDLE, BURST.
- IDLE:
  - If any `chan_req_i` is set, pick the winner by round-robin, starting the search at `last_idx+1` mod NumChan.
  - Register the one-hot grant, load `beat_cnt` with the clamped length, set `last_idx` to the winner, and go to BURST.
  - If no request is set, stay in IDLE.
- Length clamping: `chan_len_i` is sampled only at grant. A value of 0 loads 1. A value above MaxBeats loads MaxBeats.
- BURST:
  - `w_data_o` = `chan_data_i[g]`, `w_valid_o` = `chan_valid_i[g]`, `chan_ready_o[g]` = `w_ready_i`. All other `chan_ready_o` bits are 0.
  - Each handshake (`w_valid_o` && `w_ready_i`) decrements `beat_cnt`.
  - A handshake while `beat_cnt` == 1 clears the grant, pulses `burst_done_o[g]` on the next cycle, and returns to IDLE.
- Deasserting `chan_req_i` mid-burst is ignored. The burst runs to completion.
- Outside BURST: `w_valid_o` = 0, all `chan_ready_o` = 0, and `w_data_o` = 0.
- Values at reset: state IDLE, `chan_gnt_o` = 0, `beat_cnt` = 0, `last_idx` = NumChan-1 (so channel 0 wins first), `burst_done_o` = 0, `busy_o` = 0, `err_o` = 0.
- Reset asserted mid-burst drops the burst immediately, with no done pulse.

## Timing
- A request seen in IDLE at cycle t gives `chan_gnt_o` and `busy_o` = 1 at t+1. The first beat can transfer at t+1.
- The beat path is combinational through the mux, with zero added latency and no buffering.
- The last beat handshakes at cycle k:
  - `burst_done_o` pulses and `busy_o` = 0 at k+1.
  - The earliest next grant is at k+2, a single bubble cycle for re-arbitration.
- Throughput: N beats per N+1 cycles plus any midend stalls.
- `chan_gnt_o` is a registered output. `chan_ready_o` and `w_valid_o` are combinational from the grant register and from `w_ready_i` / `chan_valid_i`.

## Configuration
- Macro `APBDMA_ARB_WATCHDOG_EN`.
- Defined:
  - A stall counter runs in BURST. It resets on every handshake and otherwise increments.
  - When it reaches `TimeoutCycles`, the burst aborts: `err_o[g]` pulses at the next cycle, `burst_done_o` stays 0, the FSM returns to IDLE, and `last_idx` advances.
- Undefined: no counter is built, `err_o` = 0, and a stalled burst holds the grant indefinitely.

## Structure
- Package `apbdma_arb_pkg` holds:
  - the `arb_state_e` enum (IDLE, BURST);
  - the `LenW` and `IdxW` width functions;
  - the `len_t` / `idx_t` typedefs.
- Sub-module `apbdma_rr_pick` is a combinational round-robin picker. Inputs: request vector and start index. Outputs: one-hot grant, index, and any-valid.

## Test plan
- Single channel:
  - Stimulus: ch1 requests with len=3, midend always ready.
  - Response: grant at t+1, three beats on t+1..t+3, `burst_done_o[1]` at t+4, `busy_o` low at t+4.
- Fairness:
  - Stimulus: all four channels request len=2 continuously.
  - Response: grant order 0,1,2,3,0, with each burst exactly 2 beats and a single bubble between bursts.
- Backpressure:
  - Stimulus: len=4 with `w_ready_i` toggling 1,0,1,0….
  - Response: only 4 handshakes counted, data order preserved, and non-granted `chan_ready_o` are 0 throughout.
- Clamp:
  - Stimulus: len=0 on ch2.
  - Response: exactly 1 beat is transferred.
  - Stimulus: len=31 with MaxBeats=16.
  - Response: exactly 16 beats are transferred.
- Reset mid-burst:
  - Stimulus: `preset_n` asserted after 2 of 5 beats.
  - Response: all outputs at their reset values asynchronously, no `burst_done_o`, and ch0 wins first after release.
- Watchdog (macro defined, TimeoutCycles=8):
  - Stimulus: `w_ready_i` held 0 for 8 cycles.
  - Response: `err_o[g]` pulse, return to IDLE, and the next channel is granted.
